ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 6, instruction memory word-address width (64 words).
REQ-003 SHALL have parameter PC_W, default ADDR_W+2, byte-address program counter width.
REQ-004 SHALL have parameter RESET_PC, default 0, byte address of the first fetch.
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: start_i  in  1  leave IDLE and begin fetching.
REQ-008 SHALL have ports: imem_addr_o  out  ADDR_W  word address to combinational instruction ROM.
REQ-009 SHALL have ports: imem_q_i  in  N  ROM read data, valid in the same cycle as imem_addr_o.
REQ-010 SHALL have ports: inst_o  out  N  fetched instruction.
REQ-011 SHALL have ports: pc_o  out  PC_W  byte address of inst_o.
REQ-012 SHALL have ports: valid_o  out  1  inst_o/pc_o valid.
REQ-013 SHALL have ports: ready_i  in  1  downstream accepts; transfer when valid_o && ready_i.
REQ-014 SHALL have ports: redirect_i  in  1  branch/jump taken, fetch from redirect_pc_i.
REQ-015 SHALL have ports: redirect_pc_i  in  PC_W  redirect byte target.
REQ-016 SHALL have ports: err_o  out  1  misaligned redirect trap, sticky.

Function
REQ-017 SHALL implement states IDLE, RUN, ERR; IDLE->RUN on start_i; RUN->ERR on redirect_i with redirect_pc_i[1:0]!=0; ERR exits only on reset.
REQ-018 SHALL hold fetch register pc_q; imem_addr_o SHALL equal pc_q[PC_W-1:2] combinationally in every state.
REQ-019 SHALL hold output register {inst_o, pc_o, valid_o}, loaded with {imem_q_i, pc_q, 1} in RUN when valid_o==0 or a transfer occurs (one-cycle fetch latency, one instruction per cycle sustained).
REQ-020 SHALL advance pc_q by 4 on each output-register load; pc_q SHALL wrap modulo 2^PC_W (last word -> 0).
REQ-021 SHALL, with valid_o=1 and ready_i=0, hold inst_o, pc_o, valid_o and pc_q stable.
REQ-022 SHALL, on aligned redirect_i in RUN, set pc_q<=redirect_pc_i and valid_o<=0 next cycle, discarding the held instruction regardless of ready_i; first target instruction valid the cycle after.
REQ-023 SHALL give redirect_i priority over load/advance in the same cycle.
REQ-024 SHALL ignore redirect_i and start_i in IDLE and ERR.
REQ-025 SHALL, in ERR, drive valid_o=0 and err_o=1; err_o SHALL be 0 in IDLE and RUN.
REQ-026 SHALL ignore start_i while in RUN.

Reset
REQ-027 SHALL on rst_n=0, asynchronously: state=IDLE, pc_q=RESET_PC, valid_o=0, inst_o=0, pc_o=0, err_o=0.
REQ-028 SHALL abort any in-flight fetch or held instruction on reset mid-operation; no transfer observed after reset until start_i.

Structure
REQ-029 SHALL take the state enum (IDLE, RUN, ERR) and PC increment constant 4 from a shared package.
REQ-030 SHALL be a single module; the ROM stays outside, connected via imem_addr_o/imem_q_i.

Verification
REQ-031 SHALL check: reset, start_i pulse, ready_i=1 with 7-word program ROM -> pc_o 0x00,0x04,...,0x18 on consecutive cycles, inst_o[0]=0x0ff00593.
REQ-032 SHALL check: ready_i low 3 cycles while pc_o=0x08 -> inst_o/pc_o stable, next accepted pc_o=0x0C.
REQ-033 SHALL check: redirect_i with redirect_pc_i=0x04 while ready_i=0 -> valid_o=0 next cycle, then pc_o=0x04, inst_o=0x00000533.
REQ-034 SHALL check: run to pc_o=0xFC -> next pc_o=0x00 (wrap).
REQ-035 SHALL check: redirect_pc_i=0x06 -> err_o=1, valid_o=0, held until rst_n; start_i ignored.
REQ-036 SHALL check: rst_n low mid-stream -> all outputs zero immediately, IDLE, fetch restarts at 0x00 only after start_i.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: control states and PC step.
package ifetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Byte distance between consecutive 32-bit instruction words.
    localparam int PC_INC = 4;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: drives a combinational ROM from pc_q and presents one
// instruction per cycle through a valid/ready output register, with redirect and misalignment trap.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int N        = 32,
    parameter int ADDR_W   = 6,
    parameter int PC_W     = ADDR_W + 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [N-1:0]      imem_q_i,
    output logic [N-1:0]      inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              err_o
);

    state_t            state_reg;
    state_t            state_next;
    logic [PC_W-1:0]   pc_q;
    logic [N-1:0]      inst_reg;
    logic [PC_W-1:0]   pc_out_reg;
    logic              valid_reg;

    logic              in_run;
    logic              misaligned;
    logic              load;

    assign in_run     = (state_reg == RUN);
    assign misaligned = (redirect_pc_i[1:0] != 2'b00);
    // Redirect wins over a load in the same cycle; the output register refills whenever
    // it is empty or its current contents are being taken downstream.
    assign load       = in_run && !redirect_i && (!valid_reg || ready_i);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (redirect_i && misaligned) state_next = ERR;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        err_o   = (state_reg == ERR);
        valid_o = in_run && valid_reg;
    end

    // Fetch PC and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_W'(RESET_PC);
            inst_reg   <= '0;
            pc_out_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (in_run) begin
            if (redirect_i) begin
                // Held instruction is dropped; a misaligned target leaves pc_q alone since we trap.
                valid_reg <= 1'b0;
                if (!misaligned) begin
                    pc_q <= redirect_pc_i;
                end
            end else if (load) begin
                inst_reg   <= imem_q_i;
                pc_out_reg <= pc_q;
                valid_reg  <= 1'b1;
                pc_q       <= pc_q + PC_W'(PC_INC);
            end
        end
    end

    assign imem_addr_o = pc_q[PC_W-1:2];
    assign inst_o      = inst_reg;
    assign pc_o        = pc_out_reg;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the fetch stream.
module tb_ifetch_ctrl;

    localparam int N      = 32;
    localparam int ADDR_W = 6;
    localparam int PC_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [N-1:0]      imem_q_i;
    logic [N-1:0]      inst_o;
    logic [PC_W-1:0]   pc_o;
    logic              valid_o;
    logic              ready_i;
    logic              redirect_i;
    logic [PC_W-1:0]   redirect_pc_i;
    logic              err_o;

    logic [N-1:0] rom [64];

    int n_checks;
    int n_pass;

    // Reference model: where the next fetch comes from and what is being presented.
    bit              m_started;
    bit              m_trapped;
    logic [PC_W-1:0] m_fetch;
    bit              m_valid;
    logic [PC_W-1:0] m_pc;
    logic [N-1:0]    m_inst;

    ifetch_ctrl #(.N(N), .ADDR_W(ADDR_W), .PC_W(PC_W), .RESET_PC(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .imem_addr_o   (imem_addr_o),
        .imem_q_i      (imem_q_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .err_o         (err_o)
    );

    assign imem_q_i = rom[imem_addr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_trapped = 0;
        m_fetch   = '0;
        m_valid   = 0;
        m_pc      = '0;
        m_inst    = '0;
    endtask

    // One clock of fetch behaviour, expressed as transfers of instructions.
    task automatic model_step();
        if (m_trapped) begin
            // nothing leaves a trap but reset
        end else if (!m_started) begin
            if (start_i) m_started = 1;
        end else if (redirect_i) begin
            m_valid = 0;
            if (redirect_pc_i % 4 != 0) m_trapped = 1;
            else m_fetch = redirect_pc_i;
        end else if (!m_valid || ready_i) begin
            m_inst  = rom[m_fetch / 4];
            m_pc    = m_fetch;
            m_valid = 1;
            m_fetch = m_fetch + 8'd4;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(valid_o), 32'(m_valid && !m_trapped));
        check({tag, ".err"},   32'(err_o),   32'(m_trapped));
        check({tag, ".addr"},  32'(imem_addr_o), 32'(m_fetch / 4));
        if (m_valid && !m_trapped) begin
            check({tag, ".pc"},   32'(pc_o), 32'(m_pc));
            check({tag, ".inst"}, inst_o,    m_inst);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.inst",  inst_o,        32'h0);
        check("rst.pc",    32'(pc_o),     32'h0);
        check("rst.valid", 32'(valid_o),  32'h0);
        check("rst.err",   32'(err_o),    32'h0);
        check("rst.addr",  32'(imem_addr_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rom[0] = 32'h0ff00593;
        rom[1] = 32'h00000533;
        rom[2] = 32'h00b50533;
        rom[3] = 32'hfff58593;
        rom[4] = 32'hfe059ce3;
        rom[5] = 32'h00a02023;
        rom[6] = 32'h0000006f;
        for (int i = 7; i < 64; i++) rom[i] = $urandom;

        start_i = 0; ready_i = 0; redirect_i = 0; redirect_pc_i = '0;
        do_reset();

        // Start pulse, then a streaming run through the program.
        start_i = 1; ready_i = 1;
        tick("start");
        start_i = 0;
        check("start.valid0", 32'(valid_o), 32'h0);
        for (int k = 0; k < 7; k++) begin
            tick("stream");
            check("stream.pc", 32'(pc_o), 32'(4 * k));
            check("stream.vld", 32'(valid_o), 32'h1);
        end
        check("stream.inst0_prog", rom[0], 32'h0ff00593);

        // Restart at 0, then stall three cycles with pc_o at 0x08.
        redirect_i = 1; redirect_pc_i = 8'h00;
        tick("redir0");
        redirect_i = 0;
        tick("s0");
        tick("s1");
        tick("s2");
        check("stall.pre_pc", 32'(pc_o), 32'h08);
        ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            tick("stall");
            check("stall.pc",   32'(pc_o), 32'h08);
            check("stall.inst", inst_o, 32'h00b50533);
            check("stall.addr", 32'(imem_addr_o), 32'h03);
        end
        ready_i = 1;
        tick("release");
        check("release.pc", 32'(pc_o), 32'h0C);

        // Redirect while stalled discards the held word.
        ready_i = 0; redirect_i = 1; redirect_pc_i = 8'h04;
        tick("redir4");
        check("redir4.valid", 32'(valid_o), 32'h0);
        redirect_i = 0;
        tick("redir4.t");
        check("redir4.pc",   32'(pc_o), 32'h04);
        check("redir4.inst", inst_o, 32'h00000533);
        check("redir4.vld",  32'(valid_o), 32'h1);

        // Wrap from the last ROM word back to 0.
        ready_i = 1; redirect_i = 1; redirect_pc_i = 8'hF4;
        tick("redirF4");
        redirect_i = 0;
        tick("w0");
        tick("w1");
        tick("w2");
        check("wrap.pre", 32'(pc_o), 32'hFC);
        tick("wrap");
        check("wrap.pc",   32'(pc_o), 32'h00);
        check("wrap.inst", inst_o, 32'h0ff00593);

        // Randomized traffic with aligned redirects and spurious start pulses.
        for (int k = 0; k < 400; k++) begin
            ready_i       = ($urandom_range(0, 3) != 0);
            start_i       = ($urandom_range(0, 7) == 0);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            tick("rand");
        end
        start_i = 0; redirect_i = 0;

        // Misaligned redirect traps; trap is sticky and ignores start/redirect.
        ready_i = 1; redirect_i = 1; redirect_pc_i = 8'h06;
        tick("trap");
        check("trap.err",   32'(err_o),   32'h1);
        check("trap.valid", 32'(valid_o), 32'h0);
        redirect_pc_i = 8'h10;
        start_i = 1;
        for (int k = 0; k < 4; k++) begin
            tick("trap.hold");
            check("trap.hold.err", 32'(err_o), 32'h1);
            check("trap.hold.vld", 32'(valid_o), 32'h0);
        end
        start_i = 0; redirect_i = 0;
        do_reset();
        check("trap.cleared", 32'(err_o), 32'h0);

        // Reset asserted between edges mid-stream.
        start_i = 1; ready_i = 1;
        tick("mid.start");
        start_i = 0;
        for (int k = 0; k < 5; k++) tick("mid.run");
        #2;
        do_reset();
        ready_i = 1; redirect_i = 1; redirect_pc_i = 8'h20;
        for (int k = 0; k < 3; k++) begin
            tick("mid.idle");
            check("mid.idle.vld", 32'(valid_o), 32'h0);
        end
        redirect_i = 0; start_i = 1;
        tick("mid.restart");
        start_i = 0;
        tick("mid.first");
        check("mid.first.pc",  32'(pc_o), 32'h00);
        check("mid.first.vld", 32'(valid_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
